fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_reader_if.sv | 22 ++
 rtl/fifo_reader_skid.sv | 55 +++++
 rtl/fifo_reader.sv | 81 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared widths and reader FSM encoding for the FIFO reader slice.
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int SKID_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } reader_state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream for the FIFO reader.
interface fifo_reader_if #(
    parameter int FIFO_WIDTH = fifo_pkg::DEF_FIFO_WIDTH
);
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  underflow;
    logic [FIFO_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output rd_en, out_data, out_valid,
        input  data_out, empty, underflow, out_ready
    );

    modport slave (
        input  rd_en, out_data, out_valid,
        output data_out, empty, underflow, out_ready
    );
endinterface

// File: rtl/fifo_reader_skid.sv
// Purpose: 2-entry in-order landing buffer between FIFO read data and the stream.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: caller must not push into a full buffer unless it pops in the same cycle.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [FIFO_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [FIFO_WIDTH-1:0] head,
    output logic [1:0]            occupancy
);
    logic [FIFO_WIDTH-1:0] ent0;
    logic [FIFO_WIDTH-1:0] ent1;
    logic                  pop_ok;
    logic                  push_ok;

    assign pop_ok  = pop && (occupancy != 2'd0);
    assign push_ok = push && ((occupancy != 2'(SKID_DEPTH)) || pop_ok);
    assign head    = ent0;

    // ent0 is always the oldest word; ent1 only holds data when two are buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0      <= '0;
            ent1      <= '0;
            occupancy <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (occupancy == 2'd0) ent0 <= push_data;
                    else                   ent1 <= push_data;
                    occupancy <= occupancy + 2'd1;
                end
                2'b01: begin
                    ent0      <= ent1;
                    occupancy <= occupancy - 2'd1;
                end
                2'b11: begin
                    if (occupancy == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end else begin
                        ent0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fifo_reader.sv
// Purpose: drains a 1-cycle-latency FIFO into a valid/ready stream under an enable FSM.
// Latency: first out_valid 2 cycles after rd_en; one word per cycle in steady state.
// Backpressure: reads are credit-limited so buffered plus inflight words never exceed 2.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_reader_if.master        bus,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 underflow_err,
    output logic                 busy
);
    reader_state_e state;
    reader_state_e state_nxt;
    logic          inflight;
    logic          rd_en_c;
    logic          pop;
    logic          push;
    logic [1:0]    occupancy;
    logic [2:0]    committed;

    assign pop       = bus.out_valid && bus.out_ready;
    assign push      = inflight && !bus.underflow;
    assign committed = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};

    fifo_reader_skid #(
        .FIFO_WIDTH(FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.data_out),
        .pop       (pop),
        .head      (bus.out_data),
        .occupancy (occupancy)
    );

    assign bus.out_valid = (occupancy != 2'd0);
    assign bus.rd_en     = rd_en_c;

    always_comb begin
        state_nxt = state;
        rd_en_c   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                // A word landing after a pop frees its slot, so pop returns a credit now.
                rd_en_c = !bus.empty && (committed < 3'(SKID_DEPTH));
                if (!enable) state_nxt = STOP;
            end
            STOP: begin
                if (enable)                                 state_nxt = RUN;
                else if (!inflight && (occupancy == 2'd0)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            inflight      <= 1'b0;
            rd_count      <= '0;
            underflow_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en_c;
            if (push)          rd_count      <= rd_count + CNT_WIDTH'(1);
            if (bus.underflow) underflow_err <= 1'b1;
        end
    end
endmodule
